lsu_mem_master: RTL
===================

// Module: lsu_mem_master
// PURPOSE
//  Initiator side of the system_main_memory bus: turns core load/store requests (byte/half/word)
//  into word-aligned re/we strobes, waits on mem_ready, performs read-modify-write for sub-word
//  stores, and returns sign/zero-extended load data. Sits between the core LSU stage and memory.
//  One request in flight at a time.
// PARAMETERS
//  TIMEOUT   16   cycles waited in a *_WAIT state for mem_ready before aborting with resp_err
//  CNT_W     5    width of timeout counter (must hold TIMEOUT)
// PORTS
//  clk           in   1   system clock, all flops on rising edge
//  reset         in   1   asynchronous, active-low (0 = reset)
//  req_valid     in   1   core request valid
//  req_ready     out  1   1 = request accepted this cycle if req_valid (high only in IDLE)
//  req_we        in   1   1 = store, 0 = load
//  req_size      in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned  in   1   loads: 1 = zero-extend, 0 = sign-extend
//  req_addr      in   32  byte address
//  req_wdata     in   32  store data, right-justified (byte in [7:0], half in [15:0])
//  resp_valid    out  1   one-cycle pulse: request complete
//  resp_rdata    out  32  extended load data (0 for stores and errors); valid with resp_valid
//  resp_err      out  1   misaligned/illegal size/timeout; valid with resp_valid
//  addr          out  32  bus address, always {req_addr[31:2],2'b00}
//  wdata         out  32  bus write data
//  we            out  1   bus write strobe
//  re            out  1   bus read strobe
//  rdata         in   32  bus read data (registered by memory, valid cycle after re)
//  mem_ready     in   1   bus ready
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0;
//   addr=0; wdata=0; we=0; re=0; timeout counter=0. Reset mid-transaction abandons it, no response.
//  All outputs registered. re and we never high together; each is a single-cycle strobe.
//  Accept on req_valid&&req_ready in IDLE; latch we/size/unsigned/addr/wdata; req_ready drops next cycle.
//  FSM: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP.
//   IDLE: on accept -> RESP if misaligned (half addr[0]=1, word addr[1:0]!=0) or size=11 (err=1);
//         else load or sub-word store -> RD_REQ; word store -> WR_REQ.
//   RD_REQ: re=1, addr driven, one cycle -> RD_WAIT.
//   RD_WAIT: if mem_ready: capture rdata; load -> RESP; sub-word store -> merge -> WR_REQ.
//   WR_REQ: we=1, wdata=full word (merged for sub-word), one cycle -> WR_WAIT.
//   WR_WAIT: if mem_ready -> RESP.
//   *_WAIT: counter increments each cycle mem_ready=0; at TIMEOUT -> RESP with err=1,
//           resp_rdata=0, no further strobe (RMW write never issued). Counter clears on leaving.
//   RESP: resp_valid=1 for exactly one cycle -> IDLE (req_ready=1 next cycle).
//  Latency accept->resp_valid (mem_ready=1): error 1; word load 3; word store 3; sub-word store 5.
//  Lane select: byte lane=addr[1:0], half lane=addr[1]. Load: extract lane, extend per req_unsigned
//   (bit 7 / bit 15). Merge: replace only the addressed byte/half of captured word, keep other bits.
//  req_valid while busy is ignored (not queued); latched fields immune to input changes.
// TESTING
//  1 Preload word 0x0000_0010 = 0x8899_AABB; load byte unsigned addr 0x11 -> resp_rdata 0x0000_00AA,
//    resp_valid 3 cycles after accept, one re pulse at addr 0x10, we never high.
//  2 Same word, load half signed addr 0x12 -> 0xFFFF_8899; word load addr 0x10 -> 0x8899_AABB, err=0.
//  3 Store byte 0x55 to addr 0x13 -> re then we pulses, wdata 0x5599_AABB, resp_valid 5 cycles after accept.
//  4 Load word addr 0x02 and half addr 0x01 -> resp_err=1 after 1 cycle, re/we never asserted.
//  5 Hold mem_ready=0 during RD_WAIT of sub-word store -> resp_err=1 after TIMEOUT cycles, no we pulse;
//    release mem_ready=0 after 2 cycles instead -> normal completion 2 cycles late.
//  6 Assert reset=0 during WR_REQ -> all outputs to reset values immediately; after release req_ready=1.

Source files
------------

// File: rtl/lsu_mem_master.sv
// ---------------------------------------------------------------------------
// lsu_mem_master
//   Initiator side of the main-memory bus. Converts one core load/store
//   request at a time (byte / half / word) into word-aligned single-cycle
//   re/we strobes. Sub-word stores are done as read-modify-write. Load data
//   comes back sign- or zero-extended. A bus wait longer than TIMEOUT cycles
//   aborts the request with resp_err.
//
// Ports
//   clk, reset          clock (rising edge), async active-low reset
//   req_valid/ready     core request handshake (ready only while idle)
//   req_we, req_size,   store flag, size (00 b, 01 h, 10 w, 11 illegal),
//   req_unsigned        load zero-extend flag
//   req_addr, req_wdata byte address, right-justified store data
//   resp_valid          one-cycle completion pulse
//   resp_rdata/err      extended load data / error flag, valid with resp_valid
//   addr, wdata         word-aligned bus address, bus write data
//   we, re              single-cycle bus write / read strobes
//   rdata, mem_ready    bus read data (cycle after re), bus ready
// ---------------------------------------------------------------------------
module lsu_mem_master #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    output logic        we,
    output logic        re,
    input  logic [31:0] rdata,
    input  logic        mem_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_WR_WAIT,
        S_RESP
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // Request fields captured at accept; the core inputs are don't-care afterwards.
    logic              op_we_q, op_we_d;
    logic [1:0]        op_size_q, op_size_d;
    logic              op_unsigned_q, op_unsigned_d;
    logic [1:0]        op_lane_q, op_lane_d;
    logic [31:0]       op_wdata_q, op_wdata_d;

    logic              misaligned;

    // Pick the addressed byte/half out of a bus word and extend it.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  size,
                                                input logic        is_unsigned);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: res = is_unsigned ? {24'd0, b} : {{24{b[7]}}, b};
            SZ_HALF: res = is_unsigned ? {16'd0, h} : {{16{h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Overwrite only the addressed byte/half of the word read back from memory.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  size,
                                                input logic [31:0] data);
        logic [31:0] res;
        res = word;
        case (size)
            SZ_BYTE: begin
                case (lane)
                    2'd0:    res[7:0]   = data[7:0];
                    2'd1:    res[15:8]  = data[7:0];
                    2'd2:    res[23:16] = data[7:0];
                    default: res[31:24] = data[7:0];
                endcase
            end
            SZ_HALF: begin
                if (lane[1]) res[31:16] = data[15:0];
                else         res[15:0]  = data[15:0];
            end
            default: res = data;
        endcase
        return res;
    endfunction

    assign misaligned = (req_size == 2'b11)
                     || ((req_size == SZ_HALF) && req_addr[0])
                     || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves
        // it unassigned; a missing default would infer a latch.
        state_d       = state_q;
        resp_rdata_d  = resp_rdata_q;
        resp_err_d    = resp_err_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        cnt_d         = cnt_q;
        op_we_d       = op_we_q;
        op_size_d     = op_size_q;
        op_unsigned_d = op_unsigned_q;
        op_lane_d     = op_lane_q;
        op_wdata_d    = op_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    op_we_d       = req_we;
                    op_size_d     = req_size;
                    op_unsigned_d = req_unsigned;
                    op_lane_d     = req_addr[1:0];
                    op_wdata_d    = req_wdata;
                    addr_d        = {req_addr[31:2], 2'b00};
                    if (misaligned) begin
                        state_d      = S_RESP;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else if (!req_we || (req_size != SZ_WORD)) begin
                        state_d = S_RD_REQ;
                    end else begin
                        state_d = S_WR_REQ;
                        wdata_d = req_wdata;
                    end
                end
            end
            S_RD_REQ: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (mem_ready) begin
                    cnt_d = '0;
                    if (!op_we_q) begin
                        state_d      = S_RESP;
                        resp_err_d   = 1'b0;
                        resp_rdata_d = load_extend(rdata, op_lane_q, op_size_q, op_unsigned_q);
                    end else begin
                        state_d = S_WR_REQ;
                        wdata_d = store_merge(rdata, op_lane_q, op_size_q, op_wdata_q);
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // Abort: the RMW write (if any) is never issued.
                    cnt_d        = '0;
                    state_d      = S_RESP;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WR_REQ: state_d = S_WR_WAIT;
            S_WR_WAIT: begin
                if (mem_ready) begin
                    cnt_d        = '0;
                    state_d      = S_RESP;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d        = '0;
                    state_d      = S_RESP;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Registered outputs mirror the state being entered, so each strobe
        // and resp_valid are high for exactly the one cycle spent in that state.
        req_ready_d  = (state_d == S_IDLE);
        resp_valid_d = (state_d == S_RESP);
        re_d         = (state_d == S_RD_REQ);
        we_d         = (state_d == S_WR_REQ);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= '0;
            resp_err_q    <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            we_q          <= 1'b0;
            re_q          <= 1'b0;
            cnt_q         <= '0;
            op_we_q       <= 1'b0;
            op_size_q     <= '0;
            op_unsigned_q <= 1'b0;
            op_lane_q     <= '0;
            op_wdata_q    <= '0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_err_q    <= resp_err_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            we_q          <= we_d;
            re_q          <= re_d;
            cnt_q         <= cnt_d;
            op_we_q       <= op_we_d;
            op_size_q     <= op_size_d;
            op_unsigned_q <= op_unsigned_d;
            op_lane_q     <= op_lane_d;
            op_wdata_q    <= op_wdata_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign addr       = addr_q;
    assign wdata      = wdata_q;
    assign we         = we_q;
    assign re         = re_q;

endmodule
